// File: rtl/branch_lut_pkg.sv
// branch_lut_pkg: FSM states and entry-mode encodings for the branch-target table.
package branch_lut_pkg;
  typedef enum logic {BL_IDLE, BL_FLUSH} bl_state_t;
  localparam logic BL_ABS = 1'b0;
  localparam logic BL_REL = 1'b1;
endpackage

// File: rtl/branch_lut.sv
// branch_lut: writable branch-target table with registered lookup and sequential flush.
import branch_lut_pkg::*;

module branch_lut #(
  parameter int D = 12,
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [D-1:0]  wr_data,
  input  logic          wr_rel,
  input  logic          flush,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [D-1:0]  pc,
  output logic [D-1:0]  target,
  output logic          target_vld,
  output logic          miss,
  output logic          busy
);
  bl_state_t r_state, w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [D-1:0] r_value [N];
  logic [N-1:0] r_rel, r_vld;
  logic [D-1:0] r_target;
  logic r_target_vld, r_miss;
  logic w_idle, w_wr, w_rd, w_byp, w_vld, w_rel, w_last;
  logic [D-1:0] w_val, w_sum, w_tgt;
  assign w_idle = r_state == BL_IDLE;
  assign w_last = r_idx == AW'(N - 1);
  // flush beats a concurrent write; a concurrent read still sees pre-flush state
  assign w_wr = w_idle & wr_en & ~flush;
  assign w_rd = w_idle & rd_en;
  assign w_byp = w_wr & (wr_addr == rd_addr);
  assign w_val = w_byp ? wr_data : r_value[rd_addr];
  assign w_rel = w_byp ? wr_rel : r_rel[rd_addr];
  assign w_vld = w_byp | r_vld[rd_addr];
  assign w_sum = pc + w_val;
  assign w_tgt = !w_vld ? '0 : (w_rel == BL_REL ? w_sum : w_val);
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_idle ? (flush ? BL_FLUSH : BL_IDLE) : (w_last ? BL_IDLE : BL_FLUSH);
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= BL_IDLE;
      r_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx <= w_idle ? '0 : r_idx + 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_value <= '{default: '0};
      r_rel <= '0;
      r_vld <= '0;
    end else if (!w_idle) begin
      r_vld[r_idx] <= 1'b0;
    end else if (w_wr) begin
      r_value[wr_addr] <= wr_data;
      r_rel[wr_addr] <= wr_rel;
      r_vld[wr_addr] <= 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_target <= '0;
      r_target_vld <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_target <= w_rd ? w_tgt : '0;
      r_target_vld <= w_rd;
      r_miss <= w_rd & ~w_vld;
    end
  end
  assign target = r_target;
  assign target_vld = r_target_vld;
  assign miss = r_miss;
  assign busy = r_state == BL_FLUSH;
endmodule

// File: tb/tb_branch_lut.sv
// tb_branch_lut: directed steps against a reference model with an expected-result queue.
module tb_branch_lut;
  localparam int N = 8;
  typedef struct packed {logic [11:0] t; logic m;} exp_t;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic wr_en = 0, wr_rel = 0, flush = 0, rd_en = 0;
  logic [2:0] wr_addr = 0, rd_addr = 0;
  logic [11:0] wr_data = 0, pc = 0;
  logic [11:0] target;
  logic target_vld, miss, busy;
  int n_tot = 0, n_fail = 0;
  exp_t sb[$];
  logic [11:0] m_val [N];
  logic [N-1:0] m_rel, m_vld;
  int m_cnt, m_idx;

  branch_lut dut (
    .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rel(wr_rel), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr), .pc(pc),
    .target(target), .target_vld(target_vld), .miss(miss), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = '{default: '0};
    m_rel = '0;
    m_vld = '0;
    m_cnt = 0;
    m_idx = 0;
    sb.delete();
  endtask

  task automatic step(input logic w, input logic [2:0] wa, input logic [11:0] wd, input logic wrl,
                      input logic fl, input logic rd, input logic [2:0] ra, input logic [11:0] p);
    exp_t e;
    logic [11:0] t;
    wr_en = w; wr_addr = wa; wr_data = wd; wr_rel = wrl; flush = fl; rd_en = rd; rd_addr = ra; pc = p;
    if (m_cnt > 0) begin
      m_vld[m_idx] = 1'b0;
      m_idx++;
      m_cnt--;
    end else begin
      if (w && !fl) begin
        m_val[wa] = wd; m_rel[wa] = wrl; m_vld[wa] = 1'b1;
      end
      if (rd) begin
        t = m_rel[ra] ? m_val[ra] + p : m_val[ra];
        e.t = m_vld[ra] ? t : 12'h0;
        e.m = ~m_vld[ra];
        sb.push_back(e);
      end
      if (fl) begin
        m_cnt = N;
        m_idx = 0;
      end
    end
    @(posedge Clk);
    #1;
    wr_en = 0; flush = 0; rd_en = 0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("target_vld", 32'(target_vld), 32'd1);
      chk("target", 32'(target), 32'(e.t));
      chk("miss", 32'(miss), 32'(e.m));
    end else begin
      chk("target_vld_idle", 32'(target_vld), 32'd0);
      chk("miss_idle", 32'(miss), 32'd0);
    end
    chk("busy", 32'(busy), 32'(m_cnt > 0));
  endtask

  task automatic rd(input logic [2:0] a, input logic [11:0] p);
    step(0, 0, 0, 0, 0, 1, a, p);
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] d, input logic r);
    step(1, a, d, r, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    wr_en = 0; flush = 0; rd_en = 0;
    #1;
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_target_vld", 32'(target_vld), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int c;
    model_reset();
    @(posedge Clk);
    #1;
    do_reset();
    rd(3, 0);
    chk("miss_after_reset", 32'(miss), 32'd1);
    wr(2, 12'h014, 0);
    rd(2, 12'h100);
    chk("abs2", 32'(target), 32'h014);
    wr(5, 12'hFFF, 1);
    rd(5, 12'h004);
    chk("rel5", 32'(target), 32'h003);
    wr(1, 12'h014, 1);
    rd(1, 12'hFFB);
    chk("rel_wrap", 32'(target), 32'h00F);
    step(1, 6, 12'h0AA, 0, 0, 1, 6, 12'h555);
    chk("bypass6", 32'(target), 32'h0AA);
    step(1, 7, 12'h010, 1, 0, 1, 7, 12'h020);
    chk("bypass_rel", 32'(target), 32'h030);
    for (int i = 0; i < N; i++) wr(3'(i), 12'(i * 12'h111 + 1), 1'(i & 1));
    for (int i = 0; i < N; i++) rd(3'(i), 12'h800);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    c = 0;
    while (busy && c < 20) begin
      step(1, 3'(c), 12'hABC, 0, c == 2, 1, 3'(c), 12'h001);
      c++;
    end
    chk("busy_cycles", 32'(c), 32'd8);
    for (int i = 0; i < N; i++) rd(3'(i), 12'h123);
    chk("miss_after_flush", 32'(miss), 32'd1);
    wr(4, 12'h444, 0);
    step(0, 0, 0, 0, 1, 1, 4, 0);
    chk("flush_rd_old", 32'(target), 32'h444);
    chk("flush_rd_hit", 32'(miss), 32'd0);
    repeat (N) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 12'h321, 0, 1, 0, 0, 0);
    repeat (N) step(0, 0, 0, 0, 0, 0, 0, 0);
    rd(0, 0);
    chk("flush_wr_dropped", 32'(miss), 32'd1);
    for (int i = 0; i < N; i++) wr(3'(i), 12'h700 + 12'(i), 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("busy_mid_flush", 32'(busy), 32'd1);
    #2;
    do_reset();
    for (int i = 0; i < N; i++) rd(3'(i), 0);
    wr(3, 12'h5A5, 0);
    rd(3, 0);
    chk("pre_reset_vld", 32'(target_vld), 32'd1);
    #2;
    do_reset();
    rd(3, 0);
    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout");
  end
endmodule
